// File: rtl/tick_debouncer.sv
// -----------------------------------------------------------------------------
// tick_debouncer
//
// Debounces a raw mechanical button against a periodic one-cycle sample tick
// (normally the done strobe of a terminal-count timer). btn_in goes through a
// two-flop synchroniser. A change of level is accepted only after the
// synchronised input has held the new level for STABLE_TICKS consecutive
// ticks. If the input returns to the old level during that window, the change
// is dropped silently.
//
// Optional feature (build macro TICK_DEBOUNCER_LONG_PRESS_EN):
//   When defined, a 16-bit hold counter counts ticks while the debounced level
//   is high. It emits one long_press strobe when the count reaches LONG_TICKS.
//   When undefined, the hold counter is not built and long_press is tied to 0.
//
// Parameters:
//   STABLE_TICKS  ticks needed to qualify a level change (1..255)
//   LONG_TICKS    ticks of high level before long_press fires
//                 (STABLE_TICKS..65535, optional feature only)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   tick        one-cycle sample enable; may be asserted back-to-back
//   btn_in      raw asynchronous button input, active-high
//   db_level    debounced button level (registered)
//   rise        one-cycle strobe when db_level goes 0->1
//   fall        one-cycle strobe when db_level goes 1->0
//   long_press  one-cycle strobe per press held LONG_TICKS ticks
// -----------------------------------------------------------------------------
module tick_debouncer #(
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_in,
  output logic db_level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sync1_reg, sync2_reg;
  logic             db_level_reg, db_level_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= LOW;
      cnt_reg      <= '0;
      db_level_reg <= 1'b0;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      db_level_reg <= db_level_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
    end
  end

  // Next-state logic. The tick counter is cleared on every state change.
  // In the WAIT states, a return to the old level takes priority over a tick
  // seen in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      LOW: begin
        if (sync2_reg) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_reg) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = HIGH;
            cnt_next   = '0;
            rise_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!sync2_reg) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_reg) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_LAST) begin
            state_next = LOW;
            cnt_next   = '0;
            fall_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // The level is registered from the next state, so db_level changes in the
  // cycle after the qualifying tick. rise and fall change in that same cycle.
  assign db_level_next = (state_next == HIGH) || (state_next == WAIT_LOW);

  assign db_level = db_level_reg;
  assign rise     = rise_reg;
  assign fall     = fall_reg;

`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
  localparam logic [15:0] LONG_LAST = 16'(LONG_TICKS);

  logic [15:0] hold_reg, hold_next;
  logic [15:0] hold_inc;
  logic        long_press_reg, long_press_next;

  assign hold_inc = hold_reg + 16'd1;

  // Counts ticks while the debounced level is high (HIGH or WAIT_LOW).
  // The count saturates at LONG_LAST, so the strobe fires only once per press.
  // A WAIT_LOW glitch that reverts to HIGH keeps the count.
  // Qualifying back to LOW clears the count; this wins over a tick in the
  // same cycle.
  always_comb begin
    hold_next       = hold_reg;
    long_press_next = 1'b0;
    if (state_next == LOW) begin
      hold_next = '0;
    end else if (state_reg == WAIT_HIGH && state_next == HIGH) begin
      hold_next = '0;
    end else if ((state_reg == HIGH || state_reg == WAIT_LOW) && tick &&
                 hold_reg != LONG_LAST) begin
      hold_next       = hold_inc;
      long_press_next = (hold_inc == LONG_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg       <= '0;
      long_press_reg <= 1'b0;
    end else begin
      hold_reg       <= hold_next;
      long_press_reg <= long_press_next;
    end
  end

  assign long_press = long_press_reg;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- Consumer of the periodic one-cycle enable tick produced by the team's terminal-count timer.
- Synchronises a raw mechanical button input and qualifies it as stable only after STABLE_TICKS consecutive ticks at the same level.
- Outputs a clean level plus one-cycle rise/fall strobes that drive the LED counter logic.

Parameters:
- STABLE_TICKS, 4, consecutive ticks the synchronised input must hold before a level change is accepted; legal range 1..255.
- LONG_TICKS, 200, ticks the debounced level must stay high before long_press fires; legal range STABLE_TICKS..65535; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- tick  in  1  one-cycle sample enable, from a timer done output; any spacing, including back-to-back.
- btn_in  in  1  raw asynchronous button, active-high.
- db_level  out  1  debounced button level.
- rise  out  1  one-cycle strobe when db_level goes 0->1.
- fall  out  1  one-cycle strobe when db_level goes 1->0.
- long_press  out  1  one-cycle strobe per press held LONG_TICKS ticks; constant 0 without the feature.

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: all flops, the synchroniser, state, counters and all outputs are 0. State = LOW.
- Synchroniser: two flops on btn_in. "sync" below means the second flop. This adds 2 cycles of latency.
- Tick counter: width $clog2(STABLE_TICKS+1). It is cleared on every state entry.
- State LOW (db_level=0):
  - sync=1 -> WAIT_HIGH.
- State WAIT_HIGH (db_level=0):
  - sync=0 -> LOW. This check has priority over tick in the same cycle.
  - else if tick and cnt==STABLE_TICKS-1 -> HIGH.
  - else if tick -> cnt+1.
- State HIGH (db_level=1):
  - sync=0 -> WAIT_LOW.
- State WAIT_LOW (db_level=1):
  - Mirror of WAIT_HIGH with the levels swapped.
  - Reverts to HIGH on sync=1; qualifies to LOW.
- Outputs are registered:
  - db_level changes in the cycle after the qualifying tick.
  - rise/fall assert in that same cycle, for exactly 1 cycle.
  - rise and fall are never high together.
- Latency: from a btn_in edge to a db_level change is 2 cycles plus the time to see STABLE_TICKS ticks, plus 1 cycle.
  - The first tick may arrive immediately, so the stability window is between STABLE_TICKS-1 and STABLE_TICKS tick periods.
- STABLE_TICKS=1: the first tick seen in a WAIT state qualifies.
- tick held high continuously: one count per clock, so the block degenerates to a clock-count debouncer.
- Glitch shorter than the qualification window: returns to the original state. No strobe. db_level unchanged.
- No tick activity: the block waits indefinitely in WAIT states with no timeout.
- Reset mid-WAIT: immediate return to LOW with db_level=0. No strobe emitted on reset release, even if btn_in is held high. A held button is re-qualified normally, producing rise.

Optional Feature:
- Macro: TICK_DEBOUNCER_LONG_PRESS_EN.
- With the macro:
  - A 16-bit hold counter clears on entry to HIGH.
  - It increments on tick while in HIGH or WAIT_LOW and saturates at LONG_TICKS.
  - When it reaches LONG_TICKS, long_press pulses for 1 cycle. It fires only once per press.
  - On returning to LOW the counter clears.
  - A WAIT_LOW glitch that reverts to HIGH does not clear the counter.
- Without the macro: hold counter logic is absent and long_press is tied to 0.

Test Plan:
- Reset, then hold btn_in=1 from cycle 5, with tick every 10 cycles and STABLE_TICKS=4 -> db_level rises exactly 1 cycle after the 4th tick after sync; rise high for 1 cycle; fall stays 0.
- From HIGH, drop btn_in to 0 for 25 cycles (2 ticks), then back to 1 -> no fall, db_level stays 1, state returns to HIGH.
- Bounce pattern 1,0,1,0 toggling every 3 cycles, then settle to 0, with tick every 10 cycles -> no strobes during the bounce; a single fall after 4 settled ticks (if previously HIGH).
- tick held high, STABLE_TICKS=1, btn_in 0->1 -> rise 4 cycles after the btn_in edge (2 sync + 1 tick + 1 register).
- Assert reset_n=0 while in WAIT_HIGH with cnt=3, release with btn_in=1 -> outputs 0 during reset; after release, full re-qualification with rise after 4 more ticks.
- With TICK_DEBOUNCER_LONG_PRESS_EN and LONG_TICKS=10, hold the button 30 ticks -> exactly one long_press, 10 ticks after rise; without the macro long_press stays 0.
